// File: rtl/fifo_rr_drain_sched.sv
// Burst-limited round-robin drain of NUM_CH synchronous FIFOs into a single
// valid/ready stream, through a 2-entry output buffer with one-cycle read latency.
module fifo_rr_drain_sched #(
    parameter  int NUM_CH = 4,
    parameter  int WIDTH  = 64,
    parameter  int BURST  = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [NUM_CH-1:0]       ch_empty,
    output logic [NUM_CH-1:0]       ch_ren,
    input  logic [NUM_CH*WIDTH-1:0] ch_dout,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]         out_ch,
    input  logic                    out_ready,
    output logic                    busy
);

    // state | meaning
    // IDLE  | no current grant; next search starts at rr_start
    // GRANT | cur_ch owns the arbiter; burst_cnt reads issued in this burst
    typedef enum logic {IDLE, GRANT} state_t;

    localparam int              BC_W      = $clog2(BURST + 1);
    localparam logic [BC_W-1:0] BURST_LIM = BC_W'(BURST);

    state_t            state;
    logic [CH_W-1:0]   cur_ch;
    logic [CH_W-1:0]   rr_start;
    logic [BC_W-1:0]   burst_cnt;
    logic              inflight;
    logic [CH_W-1:0]   inflight_ch;

    logic              sk_valid;
    logic [WIDTH-1:0]  sk_data;
    logic [CH_W-1:0]   sk_ch;

    logic [1:0]        occ;
    logic              pop;
    logic [2:0]        credit_used;
    logic [2:0]        credit_limit;
    logic              issue_ok;

    logic [CH_W-1:0]   search_base;
    logic [CH_W-1:0]   probe;
    logic [CH_W-1:0]   sel;
    logic              hit;
    logic              cont;
    logic [WIDTH-1:0]  cap_data;

    function automatic logic [CH_W-1:0] ch_add(input logic [CH_W-1:0] base, input int ofs);
        int sum;
        sum = int'(base) + ofs;
        if (sum >= NUM_CH) begin
            sum = sum - NUM_CH;
        end
        return sum[CH_W-1:0];
    endfunction

    assign occ          = {1'b0, out_valid} + {1'b0, sk_valid};
    assign pop          = out_valid && out_ready;
    assign credit_used  = {1'b0, occ} + {2'b00, inflight};
    assign credit_limit = 3'd2 + {2'b00, pop};
    assign issue_ok     = enable && !reset && (credit_used < credit_limit);
    assign busy         = inflight || (occ != 2'd0);

    // Continuing the burst takes priority; otherwise scan forward, cur_ch last.
    always_comb begin
        hit         = 1'b0;
        cont        = 1'b0;
        sel         = '0;
        probe       = '0;
        search_base = (state == GRANT) ? ch_add(cur_ch, 1) : rr_start;
        if (state == GRANT && !ch_empty[cur_ch] && burst_cnt < BURST_LIM) begin
            hit  = 1'b1;
            cont = 1'b1;
            sel  = cur_ch;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                probe = ch_add(search_base, i);
                if (!hit && !ch_empty[probe]) begin
                    hit = 1'b1;
                    sel = probe;
                end
            end
        end
    end

    always_comb begin
        ch_ren = '0;
        if (issue_ok && hit) begin
            ch_ren[sel] = 1'b1;
        end
    end

    always_comb begin
        cap_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (inflight_ch == CH_W'(i)) begin
                cap_data = ch_dout[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cur_ch      <= '0;
            rr_start    <= '0;
            burst_cnt   <= '0;
            inflight    <= 1'b0;
            inflight_ch <= '0;
        end else begin
            inflight <= issue_ok && hit;
            if (issue_ok && hit) begin
                inflight_ch <= sel;
            end
            if (issue_ok) begin
                if (hit) begin
                    state     <= GRANT;
                    cur_ch    <= sel;
                    burst_cnt <= cont ? burst_cnt + BC_W'(1) : BC_W'(1);
                end else begin
                    state     <= IDLE;
                    burst_cnt <= '0;
                    if (state == GRANT) begin
                        rr_start <= ch_add(cur_ch, 1);
                    end
                end
            end else if (!enable) begin
                state     <= IDLE;
                burst_cnt <= '0;
                if (state == GRANT) begin
                    rr_start <= ch_add(cur_ch, 1);
                end
            end
        end
    end

    // Head register is the visible output; skid entry holds the second word.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            sk_valid  <= 1'b0;
            sk_data   <= '0;
            sk_ch     <= '0;
        end else if (pop) begin
            if (sk_valid) begin
                out_data <= sk_data;
                out_ch   <= sk_ch;
                sk_valid <= inflight;
                if (inflight) begin
                    sk_data <= cap_data;
                    sk_ch   <= inflight_ch;
                end
            end else if (inflight) begin
                out_data <= cap_data;
                out_ch   <= inflight_ch;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (inflight) begin
            if (!out_valid) begin
                out_valid <= 1'b1;
                out_data  <= cap_data;
                out_ch    <= inflight_ch;
            end else begin
                sk_valid <= 1'b1;
                sk_data  <= cap_data;
                sk_ch    <= inflight_ch;
            end
        end
    end

endmodule
